// File: rtl/counter_session_arbiter.sv
// -----------------------------------------------------------------------------
// counter_session_arbiter
//
// Shares one start/stop mod-N counter between NUM_REQ requesters. One
// requester at a time is granted, chosen round-robin. The arbiter pulses the
// counter's start input and counts the ticks (changes of cnt_count) the counter
// makes. Once the owner's requested duration has elapsed it pulses stop, then
// pulses done to the owner. A session ends early without done in two cases:
// the owner drops its request (abort), or the counter stops ticking for
// TIMEOUT cycles (watchdog timeout).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        level request per requester, held until done/abort
//   dur        per-requester duration in ticks, slice i = dur[i*DUR_W +: DUR_W]
//   grant      one-hot owner of the shared counter, zero when idle
//   done       one-cycle pulse to the owner on normal completion
//   timeout    one-cycle pulse when the tick watchdog aborts a session
//   busy       high while a session is in progress
//   cnt_start  one-cycle start pulse to the shared counter
//   cnt_stop   one-cycle stop pulse to the shared counter
//   cnt_count  count output of the shared counter
// -----------------------------------------------------------------------------
module counter_session_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 4,
   parameter int DUR_W   = 8,
   parameter int TIMEOUT = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*DUR_W-1:0] dur,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     timeout,
   output logic                     busy,
   output logic                     cnt_start,
   output logic                     cnt_stop,
   input  logic [CNT_W-1:0]         cnt_count
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // One spare count above TIMEOUT-1 so the watchdog cannot wrap when an
   // abort wins over a simultaneous timeout.
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);
   localparam logic [DUR_W-1:0] DUR_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_RUN   = 3'd2,
      S_STOP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Saturating increment for the elapsed-tick counter.
   function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] v);
      return (v == DUR_MAX) ? v : v + DUR_W'(1);
   endfunction

   function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // First set request at or after ptr, wrapping. MSB flags "found".
   // Scanning from the farthest offset down lets the nearest one win last.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDX_W-1:0]   ptr);
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] idx;
      res = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
   endfunction

   state_t           state, state_nx;
   logic [IDX_W-1:0] owner, owner_nx;
   logic [IDX_W-1:0] rr, rr_nx;
   logic [DUR_W-1:0] elapsed, elapsed_nx;
   logic [WD_W-1:0]  wd, wd_nx;
   logic             normal, normal_nx;
   logic [DUR_W-1:0] dur_q, dur_nx;
   logic [CNT_W-1:0] cnt_count_q;

   logic [IDX_W:0]   pick;
   logic [DUR_W-1:0] pick_dur;
   logic             tick;
   logic [DUR_W-1:0] el_inc;
   logic             tmo_hit;

   logic [NUM_REQ-1:0] grant_d, done_d;
   logic               timeout_d, busy_d, start_d, stop_d;

   // ---- stage: input sampling / tick detection ----
   // Any change of the counter output is one tick, including a wrap to 0.
   assign tick   = (cnt_count != cnt_count_q);
   assign el_inc = tick ? sat_inc(elapsed) : elapsed;

   // ---- next-state logic ----
   always_comb begin
      state_nx   = state;
      owner_nx   = owner;
      rr_nx      = rr;
      dur_nx     = dur_q;
      elapsed_nx = elapsed;
      wd_nx      = wd;
      normal_nx  = normal;
      tmo_hit    = 1'b0;
      pick       = rr_pick(req, rr);
      pick_dur   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[IDX_W-1:0] == IDX_W'(i)) pick_dur = dur[i*DUR_W +: DUR_W];
      end

      case (state)
         S_IDLE: begin
            if (pick[IDX_W]) begin
               owner_nx   = pick[IDX_W-1:0];
               dur_nx     = pick_dur;
               elapsed_nx = '0;
               // A zero-length session skips the counter entirely.
               state_nx   = (pick_dur == '0) ? S_DONE : S_START;
            end
         end
         S_START: begin
            wd_nx    = '0;
            state_nx = S_RUN;
         end
         S_RUN: begin
            elapsed_nx = el_inc;
            wd_nx      = tick ? '0 : wd + WD_W'(1);
            if (!req[owner]) begin
               state_nx  = S_STOP;
               normal_nx = 1'b0;
            end else if (!tick && (wd == WD_LIMIT)) begin
               state_nx  = S_STOP;
               normal_nx = 1'b0;
               tmo_hit   = 1'b1;
            end else if (el_inc == dur_q) begin
               state_nx  = S_STOP;
               normal_nx = 1'b1;
            end
         end
         S_STOP: begin
            if (normal) begin
               state_nx = S_DONE;
            end else begin
               state_nx = S_IDLE;
               rr_nx    = idx_inc(owner);
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            rr_nx    = idx_inc(owner);
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // ---- output decode (from next state, registered below) ----
   always_comb begin
      start_d   = (state_nx == S_START);
      stop_d    = (state_nx == S_STOP);
      busy_d    = (state_nx != S_IDLE);
      grant_d   = busy_d ? one_hot(owner_nx) : '0;
      done_d    = (state_nx == S_DONE) ? one_hot(owner_nx) : '0;
      timeout_d = tmo_hit;
   end

   // ---- stage: state register ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         owner   <= '0;
         rr      <= '0;
         elapsed <= '0;
         wd      <= '0;
         normal  <= 1'b0;
      end else begin
         state   <= state_nx;
         owner   <= owner_nx;
         rr      <= rr_nx;
         elapsed <= elapsed_nx;
         wd      <= wd_nx;
         normal  <= normal_nx;
      end
   end

   // Datapath registers carry no reset; they are rewritten before use.
   always_ff @(posedge clk) begin
      dur_q       <= dur_nx;
      cnt_count_q <= cnt_count;
   end

   // ---- stage: registered outputs ----
   always_ff @(posedge clk) begin
      if (reset) begin
         grant     <= '0;
         done      <= '0;
         timeout   <= 1'b0;
         busy      <= 1'b0;
         cnt_start <= 1'b0;
         cnt_stop  <= 1'b0;
      end else begin
         grant     <= grant_d;
         done      <= done_d;
         timeout   <= timeout_d;
         busy      <= busy_d;
         cnt_start <= start_d;
         cnt_stop  <= stop_d;
      end
   end

endmodule

// File: tb/tb_counter_session_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_session_arbiter
//
// Drives counter_session_arbiter against a mod-14 start/stop counter model
// that advances once every TICK_DIV clocks while running. A monitor collects
// one record per session (grant, start/stop/done/timeout pulse counts, ticks
// seen between start and stop) and each scenario compares those records
// against the expectations it queued when driving its stimulus.
// -----------------------------------------------------------------------------
module tb_counter_session_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int CNT_W    = 4;
   localparam int DUR_W    = 8;
   localparam int TIMEOUT  = 32;
   localparam int TICK_DIV = 2;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic [NUM_REQ-1:0]       req = '0;
   logic [NUM_REQ*DUR_W-1:0] dur = '0;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       done;
   logic                     timeout;
   logic                     busy;
   logic                     cnt_start;
   logic                     cnt_stop;
   logic [CNT_W-1:0]         cnt_count;

   counter_session_arbiter #(
      .NUM_REQ (NUM_REQ),
      .CNT_W   (CNT_W),
      .DUR_W   (DUR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .dur       (dur),
      .grant     (grant),
      .done      (done),
      .timeout   (timeout),
      .busy      (busy),
      .cnt_start (cnt_start),
      .cnt_stop  (cnt_stop),
      .cnt_count (cnt_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [NUM_REQ-1:0] hold   = '0;
   logic               freeze = 1'b0;

   // Shared mod-14 counter model.
   logic running = 1'b0;
   int   div = 0;
   always @(posedge clk) begin
      if (reset) begin
         cnt_count <= '0;
         running   <= 1'b0;
         div       <= 0;
      end else if (cnt_stop) begin
         running <= 1'b0;
      end else if (cnt_start) begin
         running <= 1'b1;
         div     <= 0;
      end else if (running && !freeze) begin
         if (div == TICK_DIV - 1) begin
            div       <= 0;
            cnt_count <= (cnt_count == 4'd13) ? 4'd0 : cnt_count + 4'd1;
         end else begin
            div <= div + 1;
         end
      end
   end

   typedef struct packed {
      logic [3:0] grant;
      logic [7:0] nstart;
      logic [7:0] nstop;
      logic [7:0] ndone;
      logic [3:0] done;
      logic [7:0] ntmo;
      logic [7:0] ticks;
      logic       last_done;
      logic       grant_bad;
      logic       overlap;
   } sess_t;

   sess_t obs_q[$];
   sess_t exp_q[$];
   sess_t cur = '0;
   logic  prev_busy = 1'b0;
   logic [CNT_W-1:0] prev_count = '0;
   int    stray = 0;

   function automatic sess_t mk(input logic [3:0] g, input int ns, input int np,
                                input int nd, input logic [3:0] d, input int nt,
                                input int tk, input logic ld);
      sess_t s;
      s           = '0;
      s.grant     = g;
      s.nstart    = 8'(ns);
      s.nstop     = 8'(np);
      s.ndone     = 8'(nd);
      s.done      = d;
      s.ntmo      = 8'(nt);
      s.ticks     = 8'(tk);
      s.last_done = ld;
      return s;
   endfunction

   function automatic string fmt(input sess_t s);
      return $sformatf("grant=%b starts=%0d stops=%0d done_cycles=%0d done=%b timeouts=%0d ticks=%0d done_at_end=%0d grant_changed=%0d start_stop_overlap=%0d",
                       s.grant, s.nstart, s.nstop, s.ndone, s.done, s.ntmo,
                       s.ticks, s.last_done, s.grant_bad, s.overlap);
   endfunction

   // Session monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (busy) begin
         if (!prev_busy) begin
            cur       = '0;
            cur.grant = grant;
         end
         if (grant !== cur.grant) cur.grant_bad = 1'b1;
         if (cur.nstart != 0 && cur.nstop == 0 && !cnt_stop && cnt_count != prev_count)
            cur.ticks = cur.ticks + 8'd1;
         cur.nstart = cur.nstart + 8'(cnt_start);
         cur.nstop  = cur.nstop + 8'(cnt_stop);
         cur.ntmo   = cur.ntmo + 8'(timeout);
         if (cnt_start && cnt_stop) cur.overlap = 1'b1;
         if (done != 0) begin
            cur.ndone = cur.ndone + 8'd1;
            cur.done  = done;
         end
         cur.last_done = (done != 0);
      end else begin
         if (prev_busy) obs_q.push_back(cur);
         if (grant != 0 || done != 0 || timeout || cnt_start || cnt_stop) stray++;
      end
      prev_busy  = busy;
      prev_count = cnt_count;
   end

   task automatic do_reset();
      reset  = 1'b1;
      req    = '0;
      hold   = '0;
      freeze = 1'b0;
      dur    = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      obs_q.delete();
      exp_q.delete();
   endtask

   // Advance until n sessions are recorded; requesters not in 'hold' drop
   // their request when they see their done pulse.
   task automatic run_sessions(input int n, input int budget);
      for (int c = 0; c < budget && obs_q.size() < n; c++) begin
         @(posedge clk);
         #1;
         if ((done & ~hold) != 0) req = req & ~(done & ~hold);
      end
   endtask

   task automatic wait_start(input int budget, output bit got);
      got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         @(posedge clk);
         #1;
         if (cnt_start) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b required 0000", grant); end
      checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b required 0000", done); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b required 0", timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (cnt_start !== 1'b0) begin errors++; $display("FAIL reset_cnt_start: got %b required 0", cnt_start); end
      checks++; if (cnt_stop !== 1'b0) begin errors++; $display("FAIL reset_cnt_stop: got %b required 0", cnt_stop); end
   endtask

   task automatic test_single();
      sess_t e, o;
      do_reset();
      dur[1*DUR_W +: DUR_W] = 8'd5;
      req = 4'b0010;
      exp_q.push_back(mk(4'b0010, 1, 1, 1, 4'b0010, 0, 5, 1'b1));
      run_sessions(1, 300);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL single_session: no session seen, required %s", fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL single_session: got %s required %s", fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_round_robin();
      sess_t e, o;
      logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      dur  = {4{8'd1}};
      hold = 4'b1111;
      req  = 4'b1111;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(order[i], 1, 1, 1, order[i], 0, 1, 1'b1));
      run_sessions(5, 600);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL round_robin: no session seen, required %s", fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL round_robin: got %s required %s", fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_wrap();
      sess_t e, o;
      do_reset();
      dur[0 +: DUR_W] = 8'd20;
      req = 4'b0001;
      exp_q.push_back(mk(4'b0001, 1, 1, 1, 4'b0001, 0, 20, 1'b1));
      run_sessions(1, 400);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL counter_wrap: no session seen, required %s", fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL counter_wrap: got %s required %s", fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_abort();
      sess_t e, o;
      bit got;
      do_reset();
      dur[0 +: DUR_W]       = 8'd40;
      dur[2*DUR_W +: DUR_W] = 8'd2;
      req = 4'b0101;
      exp_q.push_back(mk(4'b0001, 1, 1, 0, 4'b0000, 0, 255, 1'b0));
      exp_q.push_back(mk(4'b0100, 1, 1, 1, 4'b0100, 0, 2, 1'b1));
      wait_start(50, got);
      checks++;
      if (!got) begin errors++; $display("FAIL abort_start: got no cnt_start required one within 50 cycles"); end
      repeat (3) @(posedge clk);
      #1 req[0] = 1'b0;
      run_sessions(2, 400);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL abort: no session seen, required %s", fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (e.ticks == 8'hFF) o.ticks = 8'hFF;
            if (o !== e) begin errors++; $display("FAIL abort: got %s required %s", fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_timeout();
      sess_t e, o;
      bit got;
      do_reset();
      dur[0 +: DUR_W]       = 8'd10;
      dur[1*DUR_W +: DUR_W] = 8'd2;
      req = 4'b0011;
      exp_q.push_back(mk(4'b0001, 1, 1, 0, 4'b0000, 1, 0, 1'b0));
      exp_q.push_back(mk(4'b0010, 1, 1, 1, 4'b0010, 0, 2, 1'b1));
      wait_start(50, got);
      checks++;
      if (!got) begin errors++; $display("FAIL timeout_start: got no cnt_start required one within 50 cycles"); end
      freeze = 1'b1;
      run_sessions(1, 200);
      freeze = 1'b0;
      run_sessions(2, 300);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL watchdog_timeout: no session seen, required %s", fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL watchdog_timeout: got %s required %s", fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_zero_dur();
      sess_t e, o;
      do_reset();
      req = 4'b0100;
      exp_q.push_back(mk(4'b0100, 0, 0, 1, 4'b0100, 0, 0, 1'b1));
      run_sessions(1, 50);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL zero_duration: no session seen, required %s", fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL zero_duration: got %s required %s", fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      sess_t e, o;
      bit got;
      do_reset();
      dur[0 +: DUR_W] = 8'd50;
      req = 4'b0001;
      exp_q.push_back(mk(4'b0001, 1, 0, 0, 4'b0000, 0, 255, 1'b0));
      wait_start(50, got);
      checks++;
      if (!got) begin errors++; $display("FAIL midrun_start: got no cnt_start required one within 50 cycles"); end
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midrun_reset_grant: got %b required 0000", grant); end
      checks++; if (done !== 4'b0000) begin errors++; $display("FAIL midrun_reset_done: got %b required 0000", done); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL midrun_reset_timeout: got %b required 0", timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b required 0", busy); end
      checks++; if (cnt_start !== 1'b0) begin errors++; $display("FAIL midrun_reset_cnt_start: got %b required 0", cnt_start); end
      checks++; if (cnt_stop !== 1'b0) begin errors++; $display("FAIL midrun_reset_cnt_stop: got %b required 0", cnt_stop); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      req = '0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL midrun_reset: no session seen, required %s", fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (e.ticks == 8'hFF) o.ticks = 8'hFF;
            if (o !== e) begin errors++; $display("FAIL midrun_reset: got %s required %s", fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_idle_quiet();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (stray !== 0) begin
         errors++; $display("FAIL idle_outputs: got %0d idle cycles with active outputs required 0", stray);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_abort();
      test_timeout();
      test_zero_dur();
      test_reset_mid_run();
      test_idle_quiet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: got no completion required finish before 500000 time units");
      $fatal(1, "time limit");
   end

endmodule
